// File: rtl/fp32_result_normaliser.sv
// Multi-cycle FP32 add/sub back end: normalises the raw adder sum by 1-bit shifts,
// rounds to nearest-even and packs an IEEE-754 single with overflow/underflow flags.
module fp32_result_normaliser #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              sign_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [MANT_W:0]   mant_i,
  output logic              in_ready_o,
  output logic              done_o,
  output logic [31:0]       result_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  localparam logic [EXP_W:0]  EXP_ZERO = '0;
  localparam logic [EXP_W:0]  EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0]  EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [MANT_W:0] MANT_ZERO = '0;

  state_t              state_q;
  logic                sign_q;
  logic [EXP_W:0]      exp_q;
  logic [MANT_W:0]     mant_q;
  logic                guard_q;
  logic                zero_q;
  logic                inReady_q;
  logic                done_q;
  logic [31:0]         result_q;
  logic                overflow_q;
  logic                underflow_q;

  logic                roundUp;
  logic [MANT_W:0]     mantSum;
  logic [MANT_W-2:0]   fracRnd;
  logic [EXP_W:0]      expRnd;
  logic [31:0]         result_d;
  logic                overflow_d;

  // Rounding and packing, consumed only in the ROUND state. A guard bit only ever
  // comes from a single right shift, so guard=1 is always an exact tie.
  always_comb begin
    roundUp    = guard_q & mant_q[0];
    mantSum    = mant_q + {{MANT_W{1'b0}}, roundUp};
    fracRnd    = mantSum[MANT_W-2:0];
    expRnd     = exp_q;
    result_d   = {sign_q, exp_q[EXP_W-1:0], mantSum[MANT_W-2:0]};
    overflow_d = 1'b0;
    if (mantSum[MANT_W]) begin
      fracRnd = mantSum[MANT_W-1:1];
      expRnd  = exp_q + EXP_ONE;
    end
    if (zero_q) begin
      result_d = {sign_q, 31'h0};
    end else if (expRnd >= EXP_MAX) begin
      overflow_d = 1'b1;
      result_d   = {sign_q, 8'hFF, 23'h0};
    end else begin
      result_d = {sign_q, expRnd[EXP_W-1:0], fracRnd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      guard_q     <= 1'b0;
      zero_q      <= 1'b0;
      inReady_q   <= 1'b1;
      done_q      <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            sign_q      <= sign_i;
            exp_q       <= {1'b0, exp_i};
            mant_q      <= mant_i;
            guard_q     <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inReady_q   <= 1'b0;
            state_q     <= NORM;
          end else begin
            state_q <= IDLE;
          end
        end

        NORM: begin
          if (mant_q == MANT_ZERO) begin
            zero_q  <= 1'b1;
            state_q <= ROUND;
          end else if (exp_q == EXP_ZERO) begin
            underflow_q <= 1'b1;
            zero_q      <= 1'b1;
            state_q     <= ROUND;
          end else if (mant_q[MANT_W]) begin
            guard_q <= mant_q[0];
            mant_q  <= mant_q >> 1;
            exp_q   <= exp_q + EXP_ONE;
            state_q <= ROUND;
          end else if (mant_q[MANT_W-1]) begin
            state_q <= ROUND;
          end else if (exp_q == EXP_ONE) begin
            // One more left shift would need a denormal; flush instead.
            underflow_q <= 1'b1;
            zero_q      <= 1'b1;
            state_q     <= ROUND;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end
        end

        ROUND: begin
          result_q   <= result_d;
          overflow_q <= overflow_d;
          done_q     <= 1'b1;
          inReady_q  <= 1'b1;
          state_q    <= DONE;
        end

        default: begin
          state_q   <= IDLE;
          inReady_q <= 1'b1;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = inReady_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fp32_result_normaliser.sv
// Directed self-checking bench for fp32_result_normaliser with hand-computed results,
// latencies and flags.
module tb_fp32_result_normaliser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signIn = 1'b0;
  logic [7:0]  expIn = 8'h0;
  logic [24:0] mantIn = 25'h0;
  logic        inReady;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int testsRun = 0;
  int testsFailed = 0;
  int lat;
  bit readyBad;

  fp32_result_normaliser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .sign_i      (signIn),
    .exp_i       (expIn),
    .mant_i      (mantIn),
    .in_ready_o  (inReady),
    .done_o      (done),
    .result_o    (result),
    .overflow_o  (overflow),
    .underflow_o (underflow)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one operand strobe and waits (bounded) for done; lat counts the capture edge as 1.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [24:0] m,
                               input bit fromDone, output int latency);
    if (!fromDone) @(negedge clk);
    start  = 1'b1;
    signIn = s;
    expIn  = e;
    mantIn = m;
    @(posedge clk); #1;
    start   = 1'b0;
    latency = 1;
    while (!done && latency < 40) begin
      @(posedge clk); #1;
      latency++;
    end
    if (!done) checkOutput("doneTimeout", 32'(done), 32'd1);
  endtask

  task automatic checkCase(input string tag, input logic [31:0] expRes, input logic expOv,
                           input logic expUf, input int expLat, input int gotLat);
    checkOutput({tag, ".result"}, result, expRes);
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(expOv));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(expUf));
    checkOutput({tag, ".latency"}, 32'(gotLat), 32'(expLat));
  endtask

  initial begin
    #12;
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.result", result, 32'h0);
    checkOutput("reset.flags", {30'h0, overflow, underflow}, 32'h0);
    checkOutput("reset.inReady", 32'(inReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 8'h7F, 25'h0800000, 1'b0, lat);
    checkCase("normal", 32'h3F800000, 1'b0, 1'b0, 3, lat);

    applyStimulus(1'b0, 8'h7F, 25'h1000003, 1'b0, lat);
    checkCase("carryTieUp", 32'h40000002, 1'b0, 1'b0, 3, lat);
    @(posedge clk); #1;
    checkOutput("donePulse", 32'(done), 32'd0);
    checkOutput("resultHeld", result, 32'h40000002);
    checkOutput("idleReady", 32'(inReady), 32'd1);

    applyStimulus(1'b0, 8'h7F, 25'h1000001, 1'b0, lat);
    checkCase("carryTieEven", 32'h40000000, 1'b0, 1'b0, 3, lat);

    // Longest normalisation, with a stray start mid-shift that must be ignored.
    @(negedge clk);
    start  = 1'b1;
    signIn = 1'b0;
    expIn  = 8'h7F;
    mantIn = 25'h0000001;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 1;
    readyBad = inReady;
    while (!done && lat < 40) begin
      if (lat == 2) begin
        start  = 1'b1;
        signIn = 1'b1;
        expIn  = 8'h10;
        mantIn = 25'h0800000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (!done && inReady) readyBad = 1'b1;
    end
    start = 1'b0;
    if (!done) checkOutput("doneTimeout", 32'(done), 32'd1);
    checkCase("maxShift", 32'h34000000, 1'b0, 1'b0, 26, lat);
    checkOutput("maxShift.busyReady", 32'(readyBad), 32'd0);

    applyStimulus(1'b1, 8'h40, 25'h0000000, 1'b0, lat);
    checkCase("negZero", 32'h80000000, 1'b0, 1'b0, 3, lat);

    applyStimulus(1'b0, 8'h05, 25'h0000100, 1'b0, lat);
    checkCase("underflow", 32'h00000000, 1'b0, 1'b1, 7, lat);

    applyStimulus(1'b0, 8'h00, 25'h0800000, 1'b0, lat);
    checkCase("expZero", 32'h00000000, 1'b0, 1'b1, 3, lat);

    applyStimulus(1'b1, 8'hFF, 25'h0800000, 1'b0, lat);
    checkCase("exp255", 32'hFF800000, 1'b1, 1'b0, 3, lat);

    applyStimulus(1'b0, 8'hFE, 25'h1FFFFFF, 1'b0, lat);
    checkCase("overflow", 32'h7F800000, 1'b1, 1'b0, 3, lat);
    checkOutput("doneReady", 32'(inReady), 32'd1);
    applyStimulus(1'b0, 8'h7F, 25'h0800000, 1'b1, lat);
    checkCase("backToBack", 32'h3F800000, 1'b0, 1'b0, 3, lat);

    // Asynchronous reset in the middle of a long left-shift run.
    @(negedge clk);
    start  = 1'b1;
    signIn = 1'b0;
    expIn  = 8'h7F;
    mantIn = 25'h0000001;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.done", 32'(done), 32'd0);
    checkOutput("midReset.result", result, 32'h0);
    checkOutput("midReset.flags", {30'h0, overflow, underflow}, 32'h0);
    checkOutput("midReset.inReady", 32'(inReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h7F, 25'h0800000, 1'b0, lat);
    checkCase("afterReset", 32'h3F800000, 1'b0, 1'b0, 3, lat);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
